mem_stage: RTL and testbench

//  Consumer side of the EXE stage: EX/MEM pipeline register, data-memory req/ack master and MEM/WB register.

---
 rtl/mips_pkg.sv | 18 +
 rtl/dmem_req_fsm.sv | 56 +++++
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, EX/MEM ctrl bundle layout and dmem FSM encoding
package mips_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  // ctrl bundle is {Branch,MemRead,MemWrite,RegWrite,MemtoReg}
  localparam int CTRL_W        = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  typedef enum logic {
    DMEM_IDLE = 1'b0,
    DMEM_BUSY = 1'b1
  } dmem_state_e;
endpackage

// File: rtl/dmem_req_fsm.sv
// rtl/dmem_req_fsm.sv - data-memory req/ack master with timeout abort and pipeline stall
module dmem_req_fsm
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_read_i,
  input  logic mem_write_i,
  input  logic aligned_i,
  input  logic mem_ack_i,
  output logic mem_req_o,
  output logic mem_we_o,
  output logic stall_o,
  output logic mem_err_o,
  output logic ack_hit_o
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  dmem_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_op;
  logic             busy;
  logic             timeout;

  assign mem_op    = mem_read_i | mem_write_i;
  assign busy      = (state_q == DMEM_BUSY);
  assign timeout   = busy & ~mem_ack_i & (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign ack_hit_o = busy & mem_ack_i;
  assign mem_req_o = busy;
  assign mem_we_o  = busy & mem_write_i;
  // The cycle that finishes the access releases the pipeline so MEM/WB captures it.
  assign stall_o   = mem_op & aligned_i & ~(busy & (mem_ack_i | timeout));
  assign mem_err_o = (~busy & mem_op & ~aligned_i) | timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          if (mem_op & aligned_i) begin
            state_q <= DMEM_BUSY;
            cnt_q   <= '0;
          end
        end
        DMEM_BUSY: begin
          if (mem_ack_i | timeout) state_q <= DMEM_IDLE;
          else                     cnt_q   <= cnt_q + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM register, data-memory access and MEM/WB register
module mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero_flag,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_o,
  output logic              pc_src,
  output logic              mem_err,
  output logic [REG_AW-1:0] exm_rd,
  output logic              exm_regwrite,
  output logic [DATA_W-1:0] exm_alu,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [DATA_W-1:0] wb_alu,
  output logic [DATA_W-1:0] wb_rdata
);
  logic [DATA_W-1:0] exm_alu_q, exm_wdata_q;
  logic [REG_AW-1:0] exm_rd_q;
  logic [CTRL_W-1:0] exm_ctrl_q, exm_ctrl_d;
  logic              exm_zero_q;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              wb_memtoreg_q, wb_memtoreg_d;
  logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
  logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
  logic              ack_hit;

  dmem_req_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clk_i       (clk),
    .rst_i       (rst),
    .mem_read_i  (exm_ctrl_q[CTRL_MEMREAD]),
    .mem_write_i (exm_ctrl_q[CTRL_MEMWRITE]),
    .aligned_i   (exm_alu_q[1:0] == 2'b00),
    .mem_ack_i   (mem_ack),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .stall_o     (stall_o),
    .mem_err_o   (mem_err),
    .ack_hit_o   (ack_hit)
  );

  assign exm_ctrl_d = flush ? '0 : ex_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exm_alu_q   <= '0;
      exm_wdata_q <= '0;
      exm_rd_q    <= '0;
      exm_ctrl_q  <= '0;
      exm_zero_q  <= 1'b0;
    end else if (!stall_o) begin
      exm_alu_q   <= alu_result;
      exm_wdata_q <= store_data;
      exm_rd_q    <= ex_rd;
      exm_ctrl_q  <= exm_ctrl_d;
      exm_zero_q  <= zero_flag;
    end
  end

  // A stalled cycle pushes an all-zero bubble into MEM/WB.
  always_comb begin
    wb_rd_d       = '0;
    wb_regwrite_d = 1'b0;
    wb_memtoreg_d = 1'b0;
    wb_alu_d      = '0;
    wb_rdata_d    = '0;
    if (!stall_o) begin
      wb_rd_d       = exm_rd_q;
      wb_regwrite_d = exm_ctrl_q[CTRL_REGWRITE] & ~exm_ctrl_q[CTRL_MEMWRITE] & ~mem_err;
      wb_memtoreg_d = exm_ctrl_q[CTRL_MEMTOREG];
      wb_alu_d      = exm_alu_q;
      wb_rdata_d    = ack_hit ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_alu_q      <= '0;
      wb_rdata_q    <= '0;
    end else begin
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_alu_q      <= wb_alu_d;
      wb_rdata_q    <= wb_rdata_d;
    end
  end

  assign mem_addr     = exm_alu_q;
  assign mem_wdata    = exm_wdata_q;
  assign pc_src       = exm_ctrl_q[CTRL_BRANCH] & exm_zero_q;
  assign exm_rd       = exm_rd_q;
  assign exm_regwrite = exm_ctrl_q[CTRL_REGWRITE];
  assign exm_alu      = exm_alu_q;
  assign wb_rd        = wb_rd_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_alu       = wb_alu_q;
  assign wb_rdata     = wb_rdata_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  logic        clk, rst;
  logic [31:0] alu_result, store_data, mem_addr, mem_wdata, mem_rdata;
  logic        zero_flag, flush, mem_req, mem_we, mem_ack, stall_o, pc_src, mem_err;
  logic [4:0]  ex_rd, ex_ctrl, exm_rd, wb_rd;
  logic        exm_regwrite, wb_regwrite, wb_memtoreg;
  logic [31:0] exm_alu, wb_alu, wb_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_ALU  = 5'b00010;
  localparam logic [4:0] C_LW   = 5'b01011;
  localparam logic [4:0] C_SW   = 5'b00110;
  localparam logic [4:0] C_BR   = 5'b10000;

  mem_stage dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .zero_flag(zero_flag),
    .store_data(store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_o(stall_o), .pc_src(pc_src),
    .mem_err(mem_err), .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_alu(exm_alu),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_alu(wb_alu), .wb_rdata(wb_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        input logic [4:0] c, input logic z);
    alu_result = a;
    store_data = d;
    ex_rd      = rd;
    ex_ctrl    = c;
    zero_flag  = z;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    set_ex(0, 0, 0, C_NONE, 1'b0);
    #3;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall_o, 0);
    check("rst_err", mem_err, 0);
    check("rst_wb_rw", wb_regwrite, 0);
    check("rst_wb_alu", wb_alu, 0);
    tick();
    rst = 1'b0;

    // ALU op passes straight through
    set_ex(32'h10, 0, 5'd5, C_ALU, 1'b0);
    tick();
    check("alu_stall", stall_o, 0);
    check("alu_exm_rd", exm_rd, 5);
    check("alu_exm_rw", exm_regwrite, 1);
    check("alu_exm_alu", exm_alu, 32'h10);
    set_ex(0, 0, 0, C_NONE, 1'b0);
    tick();
    check("alu_wb_rd", wb_rd, 5);
    check("alu_wb_alu", wb_alu, 32'h10);
    check("alu_wb_rw", wb_regwrite, 1);
    check("alu_stall2", stall_o, 0);

    // lw with ack in first BUSY cycle
    set_ex(32'h100, 0, 5'd7, C_LW, 1'b0);
    tick();
    check("lw_stall_idle", stall_o, 1);
    check("lw_req_idle", mem_req, 0);
    set_ex(0, 0, 0, C_NONE, 1'b0);
    tick();
    check("lw_req", mem_req, 1);
    check("lw_we", mem_we, 0);
    check("lw_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    check("lw_stall_ack", stall_o, 0);
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("lw_wb_rdata", wb_rdata, 32'hDEADBEEF);
    check("lw_wb_rw", wb_regwrite, 1);
    check("lw_wb_m2r", wb_memtoreg, 1);
    check("lw_wb_rd", wb_rd, 7);
    check("lw_req_done", mem_req, 0);

    // sw acked in third BUSY cycle; RegWrite in ctrl must not reach WB
    set_ex(32'h104, 32'h55, 5'd2, C_SW, 1'b0);
    tick();
    check("sw_stall_idle", stall_o, 1);
    set_ex(0, 0, 0, C_NONE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        mem_ack = 1'b1;
        #1;
      end
      check("sw_req", mem_req, 1);
      check("sw_we", mem_we, 1);
      check("sw_addr", mem_addr, 32'h104);
      check("sw_wdata", mem_wdata, 32'h55);
      check("sw_stall", stall_o, (i != 2));
      check("sw_wb_bubble", wb_regwrite, 0);
    end
    tick();
    mem_ack = 1'b0;
    check("sw_wb_rw", wb_regwrite, 0);
    check("sw_req_done", mem_req, 0);

    // misaligned lw aborts without a request
    set_ex(32'h102, 0, 5'd8, C_LW, 1'b0);
    tick();
    check("mis_err", mem_err, 1);
    check("mis_req", mem_req, 0);
    check("mis_stall", stall_o, 0);
    set_ex(0, 0, 0, C_NONE, 1'b0);
    tick();
    check("mis_err_pulse", mem_err, 0);
    check("mis_req2", mem_req, 0);
    check("mis_wb_rw", wb_regwrite, 0);

    // lw never acked: error on the 15th BUSY cycle
    set_ex(32'h200, 0, 5'd9, C_LW, 1'b0);
    tick();
    check("to_stall_idle", stall_o, 1);
    set_ex(0, 0, 0, C_NONE, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("to_req", mem_req, 1);
      check("to_err", mem_err, (i == 14));
      check("to_stall", stall_o, (i != 14));
    end
    tick();
    check("to_req_idle", mem_req, 0);
    check("to_stall_done", stall_o, 0);
    check("to_wb_rw", wb_regwrite, 0);
    check("to_wb_rdata", wb_rdata, 0);

    // branch decision
    set_ex(0, 0, 0, C_BR, 1'b1);
    tick();
    check("br_taken", pc_src, 1);
    set_ex(0, 0, 0, C_BR, 1'b0);
    tick();
    check("br_not_taken", pc_src, 0);
    set_ex(0, 0, 0, C_NONE, 1'b0);

    // flush held across a stall only takes effect once the stall drops
    set_ex(32'h300, 0, 5'd9, C_LW, 1'b0);
    tick();
    set_ex(32'h30, 0, 5'd3, C_ALU, 1'b0);
    flush = 1'b1;
    tick();
    check("fl_hold_rd", exm_rd, 9);
    check("fl_hold_alu", exm_alu, 32'h300);
    check("fl_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    #1;
    check("fl_stall_ack", stall_o, 0);
    tick();
    mem_ack = 1'b0; mem_rdata = '0; flush = 1'b0;
    set_ex(0, 0, 0, C_NONE, 1'b0);
    check("fl_exm_rw", exm_regwrite, 0);
    check("fl_exm_rd", exm_rd, 3);
    check("fl_wb_rdata", wb_rdata, 32'h1234);
    check("fl_wb_rd", wb_rd, 9);

    // ack outside BUSY is ignored
    set_ex(32'h44, 0, 5'd4, C_ALU, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF;
    tick();
    set_ex(0, 0, 0, C_NONE, 1'b0);
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("stray_req", mem_req, 0);
    check("stray_wb_alu", wb_alu, 32'h44);
    check("stray_wb_rdata", wb_rdata, 0);

    // reset mid-BUSY drops the request immediately
    set_ex(32'h400, 0, 5'd6, C_LW, 1'b0);
    tick();
    set_ex(0, 0, 0, C_NONE, 1'b0);
    tick();
    check("rb_req_before", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rb_req", mem_req, 0);
    check("rb_stall", stall_o, 0);
    check("rb_exm_alu", exm_alu, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rb_req_after", mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
